note_judge: RTL and testbench
=============================

NOTE_JUDGE -- requirements
Module: note_judge

Interface
REQ-001 Parameter WINDOW_CYCLES, default 25'd6578947, hit-window length in clock cycles (half an eighth note at 50 MHz); legal range 2..2^25-1.
REQ-002 CLOCK_50  input  1  system clock; all flops on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pause  input  1  level; high freezes judging state.
REQ-005 beat  input  1  one-cycle strobe per eighth note, synchronous to CLOCK_50, from the note source.
REQ-006 exp_notes  input  5  expected fret chord, valid in the beat cycle; 5'b00000 = rest.
REQ-007 frets  input  5  raw player fret buttons, asynchronous, active-high.
REQ-008 strum  input  1  raw player strum button, asynchronous, active-high.
REQ-009 hit  output  1  one-cycle pulse, correct note played.
REQ-010 miss  output  1  one-cycle pulse, note missed or wrong chord.
REQ-011 overstrum  output  1  one-cycle pulse, strum with no open note.
REQ-012 score  output  16  accumulated score.
REQ-013 streak  output  8  consecutive hits.
REQ-014 multiplier  output  3  current score multiplier, 1..4.

Function
REQ-015 frets and strum each pass through a 2-flop synchronizer; strum_edge = synchronized strum high and its previous-cycle value low.
REQ-016 A strum rising at the input is seen as strum_edge on the 3rd rising clock edge after it is first sampled; the compare uses synchronized frets from that same cycle.
REQ-017 States: IDLE (no note open), WINDOW (note open); note register holds the exp_notes captured at window open.
REQ-018 IDLE -> WINDOW: beat high with exp_notes != 0; capture note, load window counter with WINDOW_CYCLES-1.
REQ-019 In WINDOW, strum_edge with synchronized frets == note: hit pulse, go IDLE.
REQ-020 In WINDOW, strum_edge with frets != note: miss pulse, go IDLE.
REQ-021 In WINDOW, counter == 0 with no strum_edge: miss pulse, go IDLE; window therefore lasts exactly WINDOW_CYCLES cycles.
REQ-022 In WINDOW, counter decrements by 1 each unpaused cycle.
REQ-023 In IDLE, strum_edge: overstrum pulse, streak cleared, score unchanged.
REQ-024 Beat with exp_notes != 0 while in WINDOW and no strum_edge: miss for old note and new window opens in the same cycle.
REQ-025 Beat and strum_edge in the same cycle: strum judged against the state before the edge (old note, or overstrum if IDLE); a nonzero beat then opens the new window in that cycle.
REQ-026 Beat with exp_notes == 0: no effect in either state.
REQ-027 At most one of hit/miss/overstrum asserted in any cycle.
REQ-028 Pulses, score, streak, multiplier are registered; all change on the same edge that ends the judging cycle (latency 1 from the judging decision).
REQ-029 On hit: streak <= streak+1 saturating at 255; score <= score + multiplier (value before the update), saturating at 65535.
REQ-030 On miss or overstrum: streak <= 0.
REQ-031 multiplier is combinational from the registered streak: 0-7 ->1, 8-15 ->2, 16-23 ->3, >=24 ->4.
REQ-032 pause high: state, counter, note, score, streak held; beat and strum_edge ignored; all pulses 0; synchronizers and edge detector keep running, so an edge during pause is discarded.

Reset
REQ-033 resetn low immediately forces IDLE, counter 0, note 0, hit/miss/overstrum 0, score 0, streak 0 (multiplier 1), synchronizer flops 0.
REQ-034 Reset asserted mid-window discards the open note with no miss pulse; first cycle after release is IDLE.

Verification
REQ-035 WINDOW_CYCLES=8; beat with exp_notes=00101, frets=00101, strum edge 3 cycles later -> single hit pulse, score 1, streak 1.
REQ-036 WINDOW_CYCLES=8; beat with 01010, no strum -> miss pulse at the edge ending the 8th window cycle, streak 0.
REQ-037 Beat with 11000, frets=10100 strummed in the window -> miss, score unchanged; strum in IDLE -> overstrum, streak 0.
REQ-038 25 consecutive hits -> multiplier 1,2,3,4 at streaks 0,8,16,24; score 8*1+8*2+8*3+1*4 = 52.
REQ-039 Nonzero beat arriving while a window is open with no strum -> miss and new window in the same cycle; beat plus strum_edge in the same cycle -> judged on the old note only.
REQ-040 pause asserted mid-window for 20 cycles -> counter, score, and pulses frozen, and a strum during pause is ignored; resetn pulsed mid-window -> all outputs 0, no miss pulse.

Source files
------------

// File: rtl/note_judge.sv
// -----------------------------------------------------------------------------
// note_judge
//
// Judges player strums against the note chart of a rhythm game.
//
// A nonzero beat opens a timing window of WINDOW_CYCLES clock cycles and
// captures the expected chord. During the window:
//   - a strum with the matching frets scores a hit;
//   - a strum with the wrong frets scores a miss;
//   - if no strum arrives before the window runs out, it scores a miss.
// A strum while no window is open scores an overstrum.
// Hits build a streak, and the streak sets a score multiplier.
//
// The player inputs are asynchronous and are synchronised inside this block.
//
// Ports
//   CLOCK_50    in   1  system clock; all flops change on its rising edge
//   resetn      in   1  asynchronous, active-low reset
//   pause       in   1  level; while high, judging state is frozen
//   beat        in   1  one-cycle strobe per eighth note
//   exp_notes   in   5  expected chord, valid in the beat cycle (0 = rest)
//   frets       in   5  raw fret buttons (asynchronous)
//   strum       in   1  raw strum button (asynchronous)
//   hit         out  1  one-cycle pulse: correct chord strummed in the window
//   miss        out  1  one-cycle pulse: wrong chord, or the window ran out
//   overstrum   out  1  one-cycle pulse: strum with no window open
//   score       out 16  accumulated score, saturates at 65535
//   streak      out  8  number of consecutive hits, saturates at 255
//   multiplier  out  3  score multiplier (1..4), derived from the streak
// -----------------------------------------------------------------------------
module note_judge #(
    parameter logic [24:0] WINDOW_CYCLES = 25'd6578947
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        pause,
    input  logic        beat,
    input  logic [4:0]  exp_notes,
    input  logic [4:0]  frets,
    input  logic        strum,
    output logic        hit,
    output logic        miss,
    output logic        overstrum,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic [2:0]  multiplier
);

    typedef enum logic {
        IDLE   = 1'b0,
        WINDOW = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronisers and strum edge detector
    // These keep running during pause. As a result, a strum edge that occurs
    // during pause is simply consumed and is not judged later.
    // -------------------------------------------------------------------------
    logic [4:0] frets_meta_reg;
    logic [4:0] frets_sync_reg;
    logic       strum_meta_reg;
    logic       strum_sync_reg;
    logic       strum_prev_reg;
    logic       strum_edge;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            frets_meta_reg <= 5'd0;
            frets_sync_reg <= 5'd0;
            strum_meta_reg <= 1'b0;
            strum_sync_reg <= 1'b0;
            strum_prev_reg <= 1'b0;
        end else begin
            frets_meta_reg <= frets;
            frets_sync_reg <= frets_meta_reg;
            strum_meta_reg <= strum;
            strum_sync_reg <= strum_meta_reg;
            strum_prev_reg <= strum_sync_reg;
        end
    end

    assign strum_edge = strum_sync_reg & ~strum_prev_reg;

    // -------------------------------------------------------------------------
    // Judging state
    // -------------------------------------------------------------------------
    state_t      state_reg,     state_next;
    logic [24:0] counter_reg,   counter_next;
    logic [4:0]  note_reg,      note_next;
    logic        hit_reg,       hit_next;
    logic        miss_reg,      miss_next;
    logic        overstrum_reg, overstrum_next;
    logic [15:0] score_reg,     score_next;
    logic [7:0]  streak_reg,    streak_next;

    // Qualified events. While paused, all judging inputs are masked so that
    // nothing in the judging state can change.
    logic        active;
    logic        strum_v;
    logic        open_v;
    logic        expired;
    logic [16:0] score_sum;

    assign active  = ~pause;
    assign strum_v = active & strum_edge;
    assign open_v  = active & beat & (exp_notes != 5'd0);
    assign expired = (counter_reg == 25'd0);

    // State register; it also holds the registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            counter_reg   <= 25'd0;
            note_reg      <= 5'd0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            overstrum_reg <= 1'b0;
            score_reg     <= 16'd0;
            streak_reg    <= 8'd0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            note_reg      <= note_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
            overstrum_reg <= overstrum_next;
            score_reg     <= score_next;
            streak_reg    <= streak_next;
        end
    end

    // Next-state logic.
    // A nonzero beat always opens a fresh window, even when it closes the
    // current one in the same cycle. The old note is judged first, by the
    // output logic below.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        note_next    = note_reg;
        if (open_v) begin
            state_next   = WINDOW;
            counter_next = WINDOW_CYCLES - 25'd1;
            note_next    = exp_notes;
        end else if (state_reg == WINDOW && active) begin
            if (strum_v || expired) begin
                state_next   = IDLE;
                counter_next = 25'd0;
            end else begin
                counter_next = counter_reg - 25'd1;
            end
        end
    end

    // Output logic: decide the judgement for the current cycle.
    // The priority order is: strum, then timeout, then a beat that
    // pre-empts the open window. This order guarantees at most one pulse.
    always_comb begin
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        overstrum_next = 1'b0;
        if (state_reg == WINDOW) begin
            if (strum_v) begin
                if (frets_sync_reg == note_reg) begin
                    hit_next = 1'b1;
                end else begin
                    miss_next = 1'b1;
                end
            end else if (active && (expired || open_v)) begin
                miss_next = 1'b1;
            end
        end else if (strum_v) begin
            overstrum_next = 1'b1;
        end
    end

    // Score and streak. The score uses the multiplier in effect before this
    // hit is counted.
    assign score_sum = {1'b0, score_reg} + {14'd0, multiplier};

    always_comb begin
        score_next  = score_reg;
        streak_next = streak_reg;
        if (hit_next) begin
            score_next  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            streak_next = (streak_reg == 8'hFF) ? 8'hFF : streak_reg + 8'd1;
        end else if (miss_next || overstrum_next) begin
            streak_next = 8'd0;
        end
    end

    // The multiplier rises by one every 8 consecutive hits, up to 4.
    always_comb begin
        if (streak_reg >= 8'd24) begin
            multiplier = 3'd4;
        end else if (streak_reg >= 8'd16) begin
            multiplier = 3'd3;
        end else if (streak_reg >= 8'd8) begin
            multiplier = 3'd2;
        end else begin
            multiplier = 3'd1;
        end
    end

    assign hit       = hit_reg;
    assign miss      = miss_reg;
    assign overstrum = overstrum_reg;
    assign score     = score_reg;
    assign streak    = streak_reg;

endmodule

// File: tb/tb_note_judge.sv
module tb_note_judge;

    logic        CLOCK_50;
    logic        resetn;
    logic        pause;
    logic        beat;
    logic [4:0]  exp_notes;
    logic [4:0]  frets;
    logic        strum;
    logic        hit;
    logic        miss;
    logic        overstrum;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;

    int n_checks = 0;
    int n_errors = 0;
    int exp_score;

    note_judge #(.WINDOW_CYCLES(25'd8)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .pause      (pause),
        .beat       (beat),
        .exp_notes  (exp_notes),
        .frets      (frets),
        .strum      (strum),
        .hit        (hit),
        .miss       (miss),
        .overstrum  (overstrum),
        .score      (score),
        .streak     (streak),
        .multiplier (multiplier)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance one clock edge, then wait 1 time unit so that outputs are
    // sampled away from the edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    // Present a one-cycle beat carrying the given chord.
    task automatic do_beat(input logic [4:0] notes);
        beat = 1'b1;
        exp_notes = notes;
        tick();
        beat = 1'b0;
        exp_notes = 5'd0;
    endtask

    // Press strum and check the pulses on the {hit,miss,overstrum} outputs.
    // The judgement must appear at the 3rd edge after the press:
    // 2 edges for the synchroniser, then 1 edge for the registered output.
    task automatic strum_check(input string tag, input logic [2:0] exp_pulse);
        strum = 1'b1;
        tick();
        tick();
        check({tag, "_pre"}, {29'd0, hit, miss, overstrum}, 32'd0);
        tick();
        check(tag, {29'd0, hit, miss, overstrum}, {29'd0, exp_pulse});
        $display("strum %s: hit=%0b miss=%0b over=%0b score=%0d streak=%0d",
                 tag, hit, miss, overstrum, score, streak);
        strum = 1'b0;
        tick();
        check({tag, "_post"}, {29'd0, hit, miss, overstrum}, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        pause = 1'b0;
        beat = 1'b0;
        exp_notes = 5'd0;
        frets = 5'd0;
        strum = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_pulses", {29'd0, hit, miss, overstrum}, 32'd0);
        check("rst_score", {16'd0, score}, 32'd0);
        check("rst_streak", {24'd0, streak}, 32'd0);
        check("rst_mult", {29'd0, multiplier}, 32'd1);
        resetn = 1'b1;
        tick();

        // Correct chord strummed in the window: hit.
        frets = 5'b00101;
        repeat (3) tick();
        do_beat(5'b00101);
        strum_check("hit1", 3'b100);
        check("hit1_score", {16'd0, score}, 32'd1);
        check("hit1_streak", {24'd0, streak}, 32'd1);

        // Strum with no window open: overstrum; streak cleared, score kept.
        strum_check("over1", 3'b001);
        check("over1_streak", {24'd0, streak}, 32'd0);
        check("over1_score", {16'd0, score}, 32'd1);

        // No strum: miss at the edge that ends the 8th window cycle.
        do_beat(5'b01010);
        repeat (7) tick();
        check("tmo_early", {31'd0, miss}, 32'd0);
        tick();
        check("tmo_miss", {31'd0, miss}, 32'd1);
        $display("timeout: miss=%0b streak=%0d", miss, streak);
        tick();
        check("tmo_after", {31'd0, miss}, 32'd0);
        check("tmo_streak", {24'd0, streak}, 32'd0);

        // Wrong chord strummed: miss, score unchanged.
        frets = 5'b10100;
        repeat (3) tick();
        do_beat(5'b11000);
        strum_check("wrong", 3'b010);
        check("wrong_score", {16'd0, score}, 32'd1);

        // Reset clears the score.
        resetn = 1'b0;
        #2;
        check("rst2_score", {16'd0, score}, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // 25 consecutive hits: the multiplier steps up every 8 hits.
        frets = 5'b00101;
        repeat (3) tick();
        exp_score = 0;
        for (int i = 0; i < 25; i++) begin
            check("run_streak", {24'd0, streak}, i);
            if (i % 8 == 0) begin
                check("run_mult", {29'd0, multiplier}, i / 8 + 1);
            end
            do_beat(5'b00101);
            strum_check("run_hit", 3'b100);
            exp_score += (i < 8) ? 1 : (i < 16) ? 2 : (i < 24) ? 3 : 4;
        end
        check("run_score_model", {16'd0, score}, exp_score);
        check("run_score", {16'd0, score}, 32'd52);
        check("run_streak_end", {24'd0, streak}, 32'd25);
        check("run_mult_end", {29'd0, multiplier}, 32'd4);

        // Restart the streak with a timeout, so the following scores are small.
        do_beat(5'b01010);
        repeat (8) tick();
        check("run_reset_miss", {31'd0, miss}, 32'd1);
        tick();

        // A beat arrives while a window is open and no strum is pending:
        // the old note is missed and the new window opens in the same cycle.
        do_beat(5'b01010);
        tick();
        tick();
        do_beat(5'b00101);
        check("ovl_pulse", {29'd0, hit, miss, overstrum}, 32'b010);
        $display("overlap beat: miss=%0b", miss);
        strum_check("ovl_hit", 3'b100);
        check("ovl_score", {16'd0, score}, 32'd53);
        check("ovl_streak", {24'd0, streak}, 32'd1);

        // A beat and a strum edge in the same cycle: the strum is judged
        // against the old note, and the new window opens.
        do_beat(5'b00101);
        strum = 1'b1;
        tick();
        tick();
        beat = 1'b1;
        exp_notes = 5'b11000;
        tick();
        beat = 1'b0;
        exp_notes = 5'd0;
        check("same_pulse", {29'd0, hit, miss, overstrum}, 32'b100);
        check("same_score", {16'd0, score}, 32'd54);
        check("same_streak", {24'd0, streak}, 32'd2);
        $display("beat+strum: hit=%0b miss=%0b score=%0d", hit, miss, score);
        strum = 1'b0;
        repeat (7) tick();
        check("same_new_early", {31'd0, miss}, 32'd0);
        tick();
        check("same_new_miss", {31'd0, miss}, 32'd1);
        tick();

        // Pause mid-window: everything is frozen, and a strum during the
        // pause is discarded.
        do_beat(5'b00101);
        tick();
        tick();
        pause = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 2) strum = 1'b1;
            if (c == 10) strum = 1'b0;
            tick();
            check("pause_pulses", {29'd0, hit, miss, overstrum}, 32'd0);
            check("pause_score", {16'd0, score}, 32'd54);
        end
        pause = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("pause_resume", {29'd0, hit, miss, overstrum}, 32'd0);
        end
        tick();
        check("pause_miss", {29'd0, hit, miss, overstrum}, 32'b010);
        $display("pause: resumed window timed out, miss=%0b score=%0d", miss, score);
        tick();

        // Reset pulsed mid-window: outputs are zero, no miss is reported,
        // and the block is idle afterwards.
        do_beat(5'b00101);
        tick();
        tick();
        resetn = 1'b0;
        #2;
        check("rstw_pulses", {29'd0, hit, miss, overstrum}, 32'd0);
        check("rstw_score", {16'd0, score}, 32'd0);
        check("rstw_streak", {24'd0, streak}, 32'd0);
        check("rstw_mult", {29'd0, multiplier}, 32'd1);
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("rstw_nomiss", {31'd0, miss}, 32'd0);
        end
        strum_check("rstw_idle", 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
